// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back path.
// Holds the FSM state encoding, default widths and the queue-entry layout.
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dir;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small write-back FIFO. Exposes the head entry and every slot's address and
// occupancy so the owner can compare decode read addresses against pending writes.
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_dir,
    input  logic [DATA_W-1:0]            push_data,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_W-1:0]            head_dir,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_dir,
    output logic [DEPTH-1:0]             entry_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] dir_mem;
    logic [DATA_W-1:0]            data_mem [DEPTH];
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [CW-1:0]                count;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head_dir  = dir_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign entry_dir = dir_mem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                dir_mem[wr_ptr]  <= push_dir;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] offset;
        offset    = '0;
        entry_vld = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset       = PW'(i) - rd_ptr;
            entry_vld[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Queues write-back results and replays them onto the register-file write port
// with programmable setup/strobe/hold timing; flags RAW hazards for decode reads.
module writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_VALID,
    input  logic              WB_EN,
    input  logic [ADDR_W-1:0] WB_DIR,
    input  logic [DATA_W-1:0] WB_DATA,
    output logic              WB_READY,
    input  logic [ADDR_W-1:0] DIR_A,
    input  logic [ADDR_W-1:0] DIR_B,
    output logic [ADDR_W-1:0] DIR_WRA,
    output logic [DATA_W-1:0] DI,
    output logic              REG_WR,
    output logic              HAZ_A,
    output logic              HAZ_B,
    output logic              BUSY
);

    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    wb_state_t                    state, state_n;
    logic [CNT_W-1:0]             cnt, cnt_n;
    logic                         push, pop;
    logic                         full, empty;
    logic [ADDR_W-1:0]            head_dir;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_dir;
    logic [DEPTH-1:0]             entry_vld;

    assign WB_READY = !full;
    // Results without a write, or targeting r0, consume the handshake only.
    assign push     = WB_VALID && !full && WB_EN && (WB_DIR != '0);
    assign BUSY     = (state != IDLE) || !empty;
    assign REG_WR   = (state != STROBE);

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (push),
        .pop       (pop),
        .push_dir  (WB_DIR),
        .push_data (WB_DATA),
        .full      (full),
        .empty     (empty),
        .head_dir  (head_dir),
        .head_data (head_data),
        .entry_dir (entry_dir),
        .entry_vld (entry_vld)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            DIR_WRA <= '0;
            DI      <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) begin
                DIR_WRA <= head_dir;
                DI      <= head_data;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_n   = CNT_W'(SETUP_CYC - 1);
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_n   = CNT_W'(STROBE_CYC - 1);
                    state_n = STROBE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        cnt_n   = CNT_W'(SETUP_CYC - 1);
                        state_n = SETUP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The in-flight write stays pending until its HOLD completes.
    always_comb begin
        HAZ_A = 1'b0;
        HAZ_B = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_dir[i] == DIR_A)) HAZ_A = 1'b1;
            if (entry_vld[i] && (entry_dir[i] == DIR_B)) HAZ_B = 1'b1;
        end
        if ((state != IDLE) && (DIR_WRA == DIR_A)) HAZ_A = 1'b1;
        if ((state != IDLE) && (DIR_WRA == DIR_B)) HAZ_B = 1'b1;
        if (DIR_A == '0) HAZ_A = 1'b0;
        if (DIR_B == '0) HAZ_B = 1'b0;
    end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed scenarios then random traffic, all checked
// each cycle against a timeline model of pending and in-flight writes.
module tb_writeback_ctrl;
    import wb_pkg::*;

    localparam int DEPTH      = 2;
    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int PERIOD     = SETUP_CYC + STROBE_CYC + HOLD_CYC;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_VALID;
    logic        WB_EN;
    logic [4:0]  WB_DIR;
    logic [31:0] WB_DATA;
    logic        WB_READY;
    logic [4:0]  DIR_A;
    logic [4:0]  DIR_B;
    logic [4:0]  DIR_WRA;
    logic [31:0] DI;
    logic        REG_WR;
    logic        HAZ_A;
    logic        HAZ_B;
    logic        BUSY;

    writeback_ctrl #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .DEPTH      (DEPTH),
        .SETUP_CYC  (SETUP_CYC),
        .STROBE_CYC (STROBE_CYC),
        .HOLD_CYC   (HOLD_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WB_VALID (WB_VALID),
        .WB_EN    (WB_EN),
        .WB_DIR   (WB_DIR),
        .WB_DATA  (WB_DATA),
        .WB_READY (WB_READY),
        .DIR_A    (DIR_A),
        .DIR_B    (DIR_B),
        .DIR_WRA  (DIR_WRA),
        .DI       (DI),
        .REG_WR   (REG_WR),
        .HAZ_A    (HAZ_A),
        .HAZ_B    (HAZ_B),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference: queued results plus the write currently on the port, tracked by
    // its age in cycles since it was taken from the queue.
    wb_entry_t m_q[$];
    bit        m_cur;
    int        m_age;
    wb_entry_t m_last;
    int        low_cnt;

    function automatic bit m_strobe();
        return m_cur && (m_age >= SETUP_CYC) && (m_age < SETUP_CYC + STROBE_CYC);
    endfunction

    function automatic bit m_haz(input logic [4:0] a);
        bit h = 0;
        if (a == 0) return 0;
        foreach (m_q[i]) if (m_q[i].dir == a) h = 1;
        if (m_cur && m_last.dir == a) h = 1;
        return h;
    endfunction

    task automatic m_step();
        bit acc;
        if (!RST) begin
            m_q.delete();
            m_cur  = 0;
            m_age  = 0;
            m_last = '0;
            return;
        end
        acc = WB_VALID && (m_q.size() < DEPTH);
        if (m_cur && m_age < PERIOD - 1) begin
            m_age++;
        end else if (m_q.size() > 0) begin
            m_last = m_q.pop_front();
            m_cur  = 1;
            m_age  = 0;
        end else begin
            m_cur = 0;
        end
        if (acc && WB_EN && WB_DIR != 0) m_q.push_back('{dir: WB_DIR, data: WB_DATA});
    endtask

    task automatic check_outputs();
        chk("reg_wr",   32'(REG_WR),   32'(!m_strobe()));
        chk("dir_wra",  32'(DIR_WRA),  32'(m_last.dir));
        chk("di",       DI,            m_last.data);
        chk("wb_ready", 32'(WB_READY), 32'(m_q.size() < DEPTH));
        chk("busy",     32'(BUSY),     32'(m_cur || m_q.size() > 0));
        chk("haz_a",    32'(HAZ_A),    32'(m_haz(DIR_A)));
        chk("haz_b",    32'(HAZ_B),    32'(m_haz(DIR_B)));
    endtask

    // Drive one cycle of inputs, check at the falling edge, then advance the model.
    task automatic cyc(input bit rst, input bit v, input bit en, input logic [4:0] d,
                       input logic [31:0] dat, input logic [4:0] a, input logic [4:0] b);
        RST = rst; WB_VALID = v; WB_EN = en; WB_DIR = d; WB_DATA = dat;
        DIR_A = a; DIR_B = b;
        @(negedge CLK);
        check_outputs();
        if (!REG_WR) low_cnt++;
        m_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] a, input logic [4:0] b);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 0, a, b);
    endtask

    function automatic logic [4:0] pick_dir();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd12;
            2: return 5'd15;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        m_cur = 0; m_age = 0; m_last = '0; low_cnt = 0;
        RST = 0; WB_VALID = 0; WB_EN = 0; WB_DIR = 0; WB_DATA = 0; DIR_A = 0; DIR_B = 0;
        @(posedge CLK); #1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Single write with hazard probes on r12/r15
        low_cnt = 0;
        cyc(1, 1, 1, 5'd12, 32'd36, 5'd12, 5'd15);
        idle(7, 5'd12, 5'd15);
        chk("single_strobe_len", 32'(low_cnt), 32'(STROBE_CYC));
        chk("single_busy_end", 32'(BUSY), 32'd0);

        // Back-to-back writes
        low_cnt = 0;
        cyc(1, 1, 1, 5'd12, 32'd36, 5'd0, 5'd15);
        cyc(1, 1, 1, 5'd15, 32'd5, 5'd0, 5'd15);
        idle(10, 5'd12, 5'd15);
        chk("b2b_strobe_len", 32'(low_cnt), 32'(2 * STROBE_CYC));

        // Discarded results
        low_cnt = 0;
        cyc(1, 1, 1, 5'd0, 32'd99, 5'd0, 5'd7);
        cyc(1, 1, 0, 5'd7, 32'd1, 5'd7, 5'd0);
        idle(6, 5'd7, 5'd0);
        chk("discard_no_strobe", 32'(low_cnt), 32'd0);

        // Backpressure: hold the third offer until accepted
        cyc(1, 1, 1, 5'd3, 32'hA, 5'd3, 5'd4);
        cyc(1, 1, 1, 5'd4, 32'hB, 5'd3, 5'd4);
        for (int i = 0; i < 20 && !WB_READY; i++) cyc(1, 1, 1, 5'd5, 32'hC, 5'd5, 5'd4);
        cyc(1, 1, 1, 5'd5, 32'hC, 5'd5, 5'd4);
        idle(16, 5'd5, 5'd3);

        // Reset while strobing with an entry queued
        cyc(1, 1, 1, 5'd9, 32'h11, 5'd9, 5'd10);
        cyc(1, 1, 1, 5'd10, 32'h22, 5'd9, 5'd10);
        for (int i = 0; i < 10 && REG_WR; i++) cyc(1, 0, 1, 0, 0, 5'd9, 5'd10);
        cyc(0, 0, 0, 0, 0, 5'd9, 5'd10);
        low_cnt = 0;
        idle(8, 5'd9, 5'd10);
        chk("post_reset_no_strobe", 32'(low_cnt), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 5) != 0), pick_dir(), $urandom,
                pick_dir(), pick_dir());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
